// File: rtl/cirno9_arb_pkg.sv
// Shared types and defaults for the cirno9 SRAM arbiter: FSM states,
// requester identifiers and the default SRAM geometry.
package cirno9_arb_pkg;

    localparam int AW_DEF = 14;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_t;

endpackage

// File: rtl/cirno9_arb_pick.sv
// Two-way requester selector: fixed LSU > IFU, or round-robin when
// CIRNO9_ARB_RR_EN is defined. The *_ok outputs ignore the requester's own valid.
module cirno9_arb_pick
    import cirno9_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
`ifdef CIRNO9_ARB_RR_EN
    input  req_t last_grant,
`endif
    output logic ifu_ok,
    output logic lsu_ok,
    output req_t grant
);

`ifdef CIRNO9_ARB_RR_EN
    // A requester yields only when the other is valid and is owed the next turn
    assign lsu_ok = ~(ifu_valid & (last_grant == REQ_LSU));
    assign ifu_ok = ~(lsu_valid & (last_grant == REQ_IFU));
`else
    assign lsu_ok = 1'b1;
    assign ifu_ok = ~lsu_valid;
`endif

    assign grant = (lsu_valid & lsu_ok) ? REQ_LSU : REQ_IFU;

endmodule

// File: rtl/cirno9_sram_arb.sv
// Shares the single-port sram32 between IFU and LSU, one access per cycle,
// with a one-entry hold register. Optional round-robin via CIRNO9_ARB_RR_EN.
module cirno9_sram_arb
    import cirno9_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ifu_cmd_valid,
    output logic            ifu_cmd_ready,
    input  logic [31:0]     ifu_cmd_addr,
    output logic            ifu_rsp_valid,
    input  logic            ifu_rsp_ready,
    output logic [DW-1:0]   ifu_rsp_rdata,
    input  logic            lsu_cmd_valid,
    output logic            lsu_cmd_ready,
    input  logic [31:0]     lsu_cmd_addr,
    input  logic            lsu_cmd_we,
    input  logic [DW-1:0]   lsu_cmd_wdata,
    input  logic [DW/8-1:0] lsu_cmd_wmask,
    output logic            lsu_rsp_valid,
    input  logic            lsu_rsp_ready,
    output logic [DW-1:0]   lsu_rsp_rdata,
    output logic            ram_cs,
    output logic            ram_we,
    output logic [DW/8-1:0] ram_wem,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);

    arb_state_t    state, state_nxt;
    req_t          owner, grant;
    logic          owner_we;
    logic [DW-1:0] hold_data;
    logic [DW-1:0] rsp_data;
    logic          ifu_ok, lsu_ok;
    logic          owner_rsp_ready, can_issue, issue;
    logic          unused_addr_bits;

`ifdef CIRNO9_ARB_RR_EN
    req_t last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= REQ_IFU;
        else if (issue)
            last_grant <= grant;
    end
`endif

    cirno9_arb_pick u_pick (
        .ifu_valid  (ifu_cmd_valid),
        .lsu_valid  (lsu_cmd_valid),
`ifdef CIRNO9_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .ifu_ok     (ifu_ok),
        .lsu_ok     (lsu_ok),
        .grant      (grant)
    );

    // Outside IDLE the owner's rsp_valid is always high, so its ready alone closes the handshake
    assign owner_rsp_ready = (owner == REQ_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
    assign can_issue       = rst_n & ((state == IDLE) | owner_rsp_ready);
    assign issue           = can_issue & (ifu_cmd_valid | lsu_cmd_valid);

    assign ifu_cmd_ready = can_issue & ifu_ok;
    assign lsu_cmd_ready = can_issue & lsu_ok;

    assign ram_cs   = issue;
    assign ram_we   = issue & (grant == REQ_LSU) & lsu_cmd_we;
    assign ram_wem  = ram_we ? lsu_cmd_wmask : '0;
    assign ram_addr = (grant == REQ_LSU) ? lsu_cmd_addr[AW+1:2] : ifu_cmd_addr[AW+1:2];
    assign ram_din  = lsu_cmd_wdata;

    assign unused_addr_bits = ^{ifu_cmd_addr[31:AW+2], ifu_cmd_addr[1:0],
                                lsu_cmd_addr[31:AW+2], lsu_cmd_addr[1:0]};

    // Write acks carry zero data both straight from BUSY and from the hold register
    assign rsp_data = (state == BUSY) ? (owner_we ? '0 : ram_dout) : hold_data;

    assign ifu_rsp_valid = (state != IDLE) & (owner == REQ_IFU);
    assign lsu_rsp_valid = (state != IDLE) & (owner == REQ_LSU);
    assign ifu_rsp_rdata = ifu_rsp_valid ? rsp_data : '0;
    assign lsu_rsp_rdata = lsu_rsp_valid ? rsp_data : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = BUSY;
            BUSY: begin
                if (owner_rsp_ready)
                    state_nxt = issue ? BUSY : IDLE;
                else
                    state_nxt = HOLD;
            end
            HOLD: if (owner_rsp_ready) state_nxt = issue ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= REQ_IFU;
            owner_we  <= 1'b0;
            hold_data <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                owner    <= grant;
                owner_we <= (grant == REQ_LSU) & lsu_cmd_we;
            end
            // ram_dout is only valid for one cycle, so a stalled response is parked here
            if ((state == BUSY) && !owner_rsp_ready)
                hold_data <= rsp_data;
        end
    end

endmodule

// File: doc/cirno9_sram_arb.md
Name: cirno9_sram_arb

Overview:
Two-requester arbiter for the single-port 32-bit SRAM (sram32) inside cirno9_cpu_top. It shares the SRAM between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). The SRAM has a fixed 1-cycle read latency. The arbiter sequences one access per cycle and routes each response back to the requester that issued it, buffering the response if that requester stalls.

Parameters:
AW, 14, SRAM word-address width (16384 words)
DW, 32, data width; fixed at 32, byte mask is DW/8 bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
ifu_cmd_valid  in  1  IFU fetch request
ifu_cmd_ready  out  1  IFU request accepted this cycle
ifu_cmd_addr  in  32  IFU byte address
ifu_rsp_valid  out  1  IFU read data valid
ifu_rsp_ready  in  1  IFU accepts response
ifu_rsp_rdata  out  DW  IFU read data
lsu_cmd_valid  in  1  LSU request
lsu_cmd_ready  out  1  LSU request accepted this cycle
lsu_cmd_addr  in  32  LSU byte address
lsu_cmd_we  in  1  1 = write
lsu_cmd_wdata  in  DW  write data
lsu_cmd_wmask  in  DW/8  byte write enables
lsu_rsp_valid  out  1  LSU response valid (read data, or write ack)
lsu_rsp_ready  in  1  LSU accepts response
lsu_rsp_rdata  out  DW  LSU read data; 0 for a write ack
ram_cs  out  1  SRAM access strobe
ram_we  out  1  SRAM write enable
ram_wem  out  DW/8  SRAM byte mask
ram_addr  out  AW  SRAM word address
ram_din  out  DW  SRAM write data
ram_dout  in  DW  SRAM read data, valid the cycle after ram_cs

Behaviour:
- Reset values:
  - state = IDLE; owner = IFU; hold_data = 0.
  - All rsp_valid = 0; all cmd_ready = 0; ram_cs = 0.
- States:
  - IDLE: nothing outstanding.
  - BUSY: access issued last cycle; ram_dout is valid now.
  - HOLD: response captured in hold_data; waiting for owner rsp_ready.
- can_issue = (state==IDLE) | (state!=IDLE & owner rsp_valid & owner rsp_ready).
  - Back-to-back issue gives 1 access per cycle.
- Arbitration (combinational, same cycle):
  - Fixed priority LSU > IFU.
  - Winner's cmd_ready = can_issue; loser's cmd_ready = 0.
  - ram_cs = can_issue & (ifu_cmd_valid | lsu_cmd_valid).
  - cmd_ready never depends on the requester's own cmd_valid.
- Address and data:
  - ram_addr = winner addr[AW+1:2]; bits [1:0] and [31:AW+2] are ignored, so 0x8000_0000 maps to word 0.
  - ram_we = LSU win & lsu_cmd_we; ram_wem = lsu_cmd_wmask for writes, else 0.
  - IFU accesses are always reads.
- Issue at cycle N: owner <= winner, state <= BUSY, and owner rsp_valid = 1 in cycle N+1.
  - BUSY: rdata = ram_dout (0 for writes).
  - HOLD: rdata = hold_data.
- Stall handling:
  - BUSY & owner rsp_ready = 0: latch ram_dout (or 0 for a write) into hold_data, go to HOLD. No issue this cycle.
  - BUSY/HOLD & handshake: if an issue happens this cycle go to BUSY, else go to IDLE.
- The non-owner's rsp_valid is always 0. Responses return strictly in issue order (at most 1 outstanding).
- A write followed immediately by a read to the same word returns the new data (SRAM write-first not required; the read issues a cycle later).
- Reset asserted mid-transaction: return to IDLE immediately; the in-flight response is dropped and no rsp_valid follows.

Optional Feature:
CIRNO9_ARB_RR_EN
- Defined: round-robin arbitration. A last_grant flop (reset = IFU) gives priority to the requester not granted last when both are valid. last_grant updates only on an issue.
- Undefined: fixed LSU > IFU; no last_grant flop.

Decomposition:
- cirno9_arb_pkg:
  - State encodings IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2.
  - Requester IDs REQ_IFU = 1'b0, REQ_LSU = 1'b1.
  - AW/DW defaults.
- One sub-module, cirno9_arb_pick: 2-way priority / round-robin selector (valids, last_grant -> grant).
- FSM, response routing and hold register stay in the top module.

Test Plan:
- IFU-only read stream: 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles with ifu_rsp_ready = 1 -> ram_addr 0, 1, 2; rsp_valid on cycles N+1..N+3 with words 0..2.
- Simultaneous IFU and LSU read, fixed priority: LSU granted first, IFU second cycle; each rsp goes to its own port only. With RR_EN and last_grant = LSU -> IFU first.
- LSU write 0xDEADBEEF, mask 4'b0011, to word 5, then LSU read of word 5 -> write ack with rdata 0; read returns 0x????BEEF with the low half updated.
- Response stall: IFU read, ifu_rsp_ready held low 3 cycles -> state HOLD; rdata stable; LSU cmd_ready = 0 throughout; release -> handshake, and LSU issues in the same cycle.
- Reset mid-BUSY: assert rst_n = 0 the cycle after issue -> rsp_valid never asserts; after release, state is IDLE and the first new read completes normally.
- Address aliasing: read 0x8001_0000 with AW = 14 -> ram_addr = 0.
